// File: rtl/mu0_ctrl.sv
// mu0_ctrl - fetch/execute sequencer for the MU0 processor.
//
// Steps FETCH -> EXEC -> FETCH, or ends in HALT. It drives the ALU mode,
// the PC/ACC/IR load strobes and the mux selects, and runs the memory
// request/ready handshake. All outputs are combinational decodes of the
// state, opcode, ACC flags and mem_ready. While reset is high every output
// is forced to 0.
//
// Build option: define MU0_TRAP_EN to turn opcodes 8-15 into traps. With
// the option, those opcodes halt the processor and the extra output `trap`
// is set. Without it, they are single-cycle NOPs and `trap` does not exist.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   opcode     in   IR[15:12] of the latched instruction
//   acc_zero   in   ACC == 0
//   acc_neg    in   ACC sign bit
//   mem_ready  in   memory completes the current request this cycle
//   mem_req    out  memory access request
//   mem_we     out  1 = write ACC to memory, 0 = read
//   addr_sel   out  memory address: 0 = PC, 1 = IR[11:0]
//   alu_m      out  ALU mode: 00 pass Y, 01 X+Y, 10 X+1, 11 X-Y
//   x_sel      out  ALU X: 0 = PC, 1 = ACC
//   y_sel      out  ALU Y: 0 = memory data, 1 = IR[11:0]
//   acc_ld     out  load ACC from ALU Z
//   pc_ld      out  load PC from ALU Z
//   ir_ld      out  load IR from memory data
//   halted     out  processor stopped
//   trap       out  (MU0_TRAP_EN only) halted on an illegal opcode

module mu0_ctrl #(
    parameter int unsigned MAXWIDTH = 16,
    parameter int unsigned OPW      = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic           acc_zero,
    input  logic           acc_neg,
    input  logic           mem_ready,
    output logic           mem_req,
    output logic           mem_we,
    output logic           addr_sel,
    output logic [1:0]     alu_m,
    output logic           x_sel,
    output logic           y_sel,
    output logic           acc_ld,
    output logic           pc_ld,
    output logic           ir_ld,
    output logic           halted
`ifdef MU0_TRAP_EN
    ,
    output logic           trap
`endif
);

    // The opcode field sits above a 12-bit address field in the instruction word.
    if (MAXWIDTH != OPW + 12) begin : g_width_check
        $error("mu0_ctrl: MAXWIDTH must equal OPW + 12");
    end

    localparam logic [OPW-1:0] OP_LDA = OPW'(0);
    localparam logic [OPW-1:0] OP_STA = OPW'(1);
    localparam logic [OPW-1:0] OP_ADD = OPW'(2);
    localparam logic [OPW-1:0] OP_SUB = OPW'(3);
    localparam logic [OPW-1:0] OP_JMP = OPW'(4);
    localparam logic [OPW-1:0] OP_JGE = OPW'(5);
    localparam logic [OPW-1:0] OP_JNE = OPW'(6);
    localparam logic [OPW-1:0] OP_STP = OPW'(7);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

`ifdef MU0_TRAP_EN
    logic   r_trap;
    logic   w_trap_set;
`endif

    logic       w_req;
    logic       w_we;
    logic       w_asel;
    logic [1:0] w_alu;
    logic       w_xsel;
    logic       w_ysel;
    logic       w_accld;
    logic       w_pcld;
    logic       w_irld;
    logic       w_halt;

    // Output and next-state decode. The reset gate is applied here as well
    // as in the state register, so an access that reset interrupts raises
    // no load strobe.
    always_comb begin
        w_next  = r_state;
        w_req   = 1'b0;
        w_we    = 1'b0;
        w_asel  = 1'b0;
        w_alu   = 2'b00;
        w_xsel  = 1'b0;
        w_ysel  = 1'b0;
        w_accld = 1'b0;
        w_pcld  = 1'b0;
        w_irld  = 1'b0;
        w_halt  = 1'b0;
`ifdef MU0_TRAP_EN
        w_trap_set = 1'b0;
`endif
        if (!reset) begin
            unique case (r_state)
                S_FETCH: begin
                    w_req = 1'b1;
                    w_alu = 2'b10;
                    if (mem_ready) begin
                        w_irld = 1'b1;
                        w_pcld = 1'b1;
                        w_next = S_EXEC;
                    end
                end
                S_EXEC: begin
                    w_next = S_FETCH;
                    case (opcode)
                        OP_LDA: begin
                            w_req   = 1'b1;
                            w_asel  = 1'b1;
                            w_accld = mem_ready;
                            if (!mem_ready) w_next = S_EXEC;
                        end
                        OP_STA: begin
                            w_req  = 1'b1;
                            w_we   = 1'b1;
                            w_asel = 1'b1;
                            if (!mem_ready) w_next = S_EXEC;
                        end
                        OP_ADD, OP_SUB: begin
                            w_req   = 1'b1;
                            w_asel  = 1'b1;
                            w_alu   = (opcode == OP_SUB) ? 2'b11 : 2'b01;
                            w_xsel  = 1'b1;
                            w_accld = mem_ready;
                            if (!mem_ready) w_next = S_EXEC;
                        end
                        OP_JMP: begin
                            w_ysel = 1'b1;
                            w_pcld = 1'b1;
                        end
                        OP_JGE: begin
                            w_ysel = 1'b1;
                            w_pcld = ~acc_neg;
                        end
                        OP_JNE: begin
                            w_ysel = 1'b1;
                            w_pcld = ~acc_zero;
                        end
                        OP_STP: begin
                            w_next = S_HALT;
                        end
                        default: begin
`ifdef MU0_TRAP_EN
                            w_next     = S_HALT;
                            w_trap_set = 1'b1;
`else
                            w_next = S_FETCH;
`endif
                        end
                    endcase
                end
                S_HALT: begin
                    w_halt = 1'b1;
                end
                default: begin
                    w_next = S_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

`ifdef MU0_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_trap <= 1'b0;
        end else if (w_trap_set) begin
            r_trap <= 1'b1;
        end
    end

    assign trap = r_trap & ~reset;
`endif

    assign mem_req  = w_req;
    assign mem_we   = w_we;
    assign addr_sel = w_asel;
    assign alu_m    = w_alu;
    assign x_sel    = w_xsel;
    assign y_sel    = w_ysel;
    assign acc_ld   = w_accld;
    assign pc_ld    = w_pcld;
    assign ir_ld    = w_irld;
    assign halted   = w_halt;

endmodule

// File: tb/tb_mu0_ctrl.sv
// Testbench for mu0_ctrl. The stimulus process drives one cycle of inputs
// and queues the hand-computed output vector for that cycle. The monitor
// samples the DUT on the falling edge and compares it with the queue head.
// Vector layout: {req, we, asel, alu[1:0], xsel, ysel, accld, pcld, irld, halted, trap}.

module tb_mu0_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] opcode = 4'd0;
    logic       acc_zero = 1'b0;
    logic       acc_neg = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, addr_sel, x_sel, y_sel, acc_ld, pc_ld, ir_ld, halted;
    logic [1:0] alu_m;
    logic       trap_w;

    mu0_ctrl #(.MAXWIDTH(16), .OPW(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .acc_zero(acc_zero), .acc_neg(acc_neg), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .alu_m(alu_m), .x_sel(x_sel), .y_sel(y_sel),
        .acc_ld(acc_ld), .pc_ld(pc_ld), .ir_ld(ir_ld), .halted(halted)
`ifdef MU0_TRAP_EN
        , .trap(trap_w)
`endif
    );
`ifndef MU0_TRAP_EN
    assign trap_w = 1'b0;
`endif

    always #5 clk = ~clk;

    localparam logic [11:0] E_IDLE = 12'b0_0_0_00_0_0_0_0_0_0_0;
    localparam logic [11:0] E_FW   = 12'b1_0_0_10_0_0_0_0_0_0_0;
    localparam logic [11:0] E_FR   = 12'b1_0_0_10_0_0_0_1_1_0_0;
    localparam logic [11:0] E_LDA  = 12'b1_0_1_00_0_0_1_0_0_0_0;
    localparam logic [11:0] E_ADDW = 12'b1_0_1_01_1_0_0_0_0_0_0;
    localparam logic [11:0] E_ADDR = 12'b1_0_1_01_1_0_1_0_0_0_0;
    localparam logic [11:0] E_SUB  = 12'b1_0_1_11_1_0_1_0_0_0_0;
    localparam logic [11:0] E_STA  = 12'b1_1_1_00_0_0_0_0_0_0_0;
    localparam logic [11:0] E_JPC  = 12'b0_0_0_00_0_1_0_1_0_0_0;
    localparam logic [11:0] E_JNO  = 12'b0_0_0_00_0_1_0_0_0_0_0;
    localparam logic [11:0] E_HALT = 12'b0_0_0_00_0_0_0_0_0_1_0;
    localparam logic [11:0] E_TRAP = 12'b0_0_0_00_0_0_0_0_0_1_1;

    typedef struct {
        logic [11:0] exp;
        string       name;
    } item_t;

    item_t q[$];
    int    checks = 0;
    int    failures = 0;
    bit    stim_done = 1'b0;

    // One clock cycle of stimulus plus its expected outputs.
    task automatic step(input bit rst, input logic [3:0] op, input bit z, input bit n,
                        input bit rdy, input logic [11:0] exp, input string name);
        item_t it;
        @(posedge clk);
        #1;
        reset     = rst;
        opcode    = op;
        acc_zero  = z;
        acc_neg   = n;
        mem_ready = rdy;
        it.exp    = exp;
        it.name   = name;
        q.push_back(it);
    endtask

    // Monitor: compares every cycle for which a vector is queued.
    initial begin
        item_t       it;
        logic [11:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                it  = q.pop_front();
                act = {mem_req, mem_we, addr_sel, alu_m, x_sel, y_sel,
                       acc_ld, pc_ld, ir_ld, halted, trap_w};
                checks++;
                if (act !== it.exp) begin
                    failures++;
                    $display("FAIL %s: got %b expected %b", it.name, act, it.exp);
                end
            end
        end
    end

    initial begin
        // Reset held 3 cycles with ready high: no request may appear.
        for (int i = 0; i < 3; i++) step(1, 4'd0, 0, 0, 1, E_IDLE, "reset");
        // Release: fetch completes at once.
        step(0, 4'd0, 0, 0, 1, E_FR,   "fetch_first");
        step(0, 4'd0, 0, 0, 1, E_LDA,  "lda");
        // ADD with three wait states.
        step(0, 4'd2, 0, 0, 1, E_FR,   "fetch_add");
        for (int i = 0; i < 3; i++) step(0, 4'd2, 0, 0, 0, E_ADDW, "add_wait");
        step(0, 4'd2, 0, 0, 1, E_ADDR, "add_done");
        // Fetch with one wait state, then STA.
        step(0, 4'd1, 0, 0, 0, E_FW,   "fetch_wait");
        step(0, 4'd1, 0, 0, 1, E_FR,   "fetch_sta");
        step(0, 4'd1, 0, 0, 1, E_STA,  "sta");
        // Conditional and unconditional jumps; ready is ignored.
        step(0, 4'd5, 0, 1, 1, E_FR,   "fetch_jge");
        step(0, 4'd5, 0, 1, 1, E_JNO,  "jge_neg");
        step(0, 4'd5, 0, 0, 1, E_FR,   "fetch_jge2");
        step(0, 4'd5, 0, 0, 0, E_JPC,  "jge_pos");
        step(0, 4'd6, 1, 0, 1, E_FR,   "fetch_jne");
        step(0, 4'd6, 1, 0, 1, E_JNO,  "jne_zero");
        step(0, 4'd6, 0, 0, 1, E_FR,   "fetch_jne2");
        step(0, 4'd6, 0, 0, 0, E_JPC,  "jne_nonzero");
        step(0, 4'd4, 0, 0, 1, E_FR,   "fetch_jmp");
        step(0, 4'd4, 1, 1, 1, E_JPC,  "jmp");
        step(0, 4'd3, 0, 0, 1, E_FR,   "fetch_sub");
        step(0, 4'd3, 0, 0, 1, E_SUB,  "sub");
        // Opcode 9: NOP or trap.
        step(0, 4'd9, 0, 0, 1, E_FR,   "fetch_op9");
        step(0, 4'd9, 0, 0, 1, E_IDLE, "op9_exec");
`ifdef MU0_TRAP_EN
        step(0, 4'd9, 0, 0, 1, E_TRAP, "op9_trap");
        step(0, 4'd9, 0, 0, 0, E_TRAP, "op9_trap_hold");
`else
        step(0, 4'd9, 0, 0, 1, E_FR,   "op9_nop_fetch");
`endif
        step(1, 4'd0, 0, 0, 1, E_IDLE, "reset_mid");
        // STP: halted from the third cycle; ready toggling is ignored.
        step(0, 4'd7, 0, 0, 1, E_FR,   "fetch_stp");
        step(0, 4'd7, 0, 0, 1, E_IDLE, "stp_exec");
        for (int i = 0; i < 4; i++) step(0, 4'd7, 0, 0, i[0], E_HALT, "halt");
        step(1, 4'd7, 0, 0, 1, E_IDLE, "halt_reset");
        step(0, 4'd0, 0, 0, 0, E_FW,   "after_halt");
        step(0, 4'd0, 0, 0, 1, E_FR,   "after_halt_fetch");
        stim_done = 1'b1;
    end

    initial begin
        int budget = 0;
        wait (stim_done);
        while (q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        @(posedge clk);
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mu0_ctrl.md
Name: mu0_ctrl

Overview:
- Fetch/execute sequencer for the MU0 processor.
- Drives the 2-bit ALU mode `alu_m` and the datapath register enables and mux selects for the PC, ACC and IR.
- Runs the memory request/ready handshake.
- Consumes the IR opcode and the accumulator status flags.
- Sits between the 16-bit datapath (ALU, ACC, PC, IR) and the memory.

Parameters:
- MAXWIDTH, 16, datapath width taken from defs.h. Used only for documentation; the controller itself sees no data.
- OPW, 4, opcode width (IR[15:12]).

Ports:
- clk  input  1  system clock; rising edge.
- reset  input  1  synchronous, active-high reset.
- opcode  input  OPW  IR[15:12] of the currently latched instruction.
- acc_zero  input  1  ACC == 0.
- acc_neg  input  1  ACC[MAXWIDTH-1].
- mem_ready  input  1  memory completes the current request this cycle.
- mem_req  output  1  memory access request.
- mem_we  output  1  1 = write ACC to memory; 0 = read.
- addr_sel  output  1  memory address: 0 = PC, 1 = IR[11:0].
- alu_m  output  2  ALU mode: 00 pass Y, 01 X+Y, 10 X+1, 11 X-Y.
- x_sel  output  1  ALU X source: 0 = PC, 1 = ACC.
- y_sel  output  1  ALU Y source: 0 = memory read data, 1 = zero-extended IR[11:0].
- acc_ld  output  1  load ACC from ALU Z.
- pc_ld  output  1  load PC from ALU Z.
- ir_ld  output  1  load IR from memory read data.
- halted  output  1  processor stopped.

Behaviour:
- State register: FETCH, EXEC, HALT. Outputs are combinational decodes of state, opcode, flags and mem_ready.
- Reset:
  - While `reset` is high, all outputs are forced to 0.
  - `alu_m` is 00 and `halted` is 0.
  - The next state is FETCH.
  - Reset mid-access aborts the access; no load strobe fires.
- Unlisted outputs are 0 in every state.
- FETCH:
  - mem_req=1, mem_we=0, addr_sel=0, alu_m=10, x_sel=0.
  - On mem_ready=1: ir_ld=1, pc_ld=1, next state EXEC.
  - Otherwise stay in FETCH with the request held and no strobes.
- EXEC, opcode 0 LDA: mem_req=1, addr_sel=1, alu_m=00, y_sel=0. On ready: acc_ld=1, go to FETCH.
- EXEC, opcode 1 STA: mem_req=1, mem_we=1, addr_sel=1. On ready: go to FETCH.
- EXEC, opcode 2 ADD: mem_req=1, addr_sel=1, alu_m=01, x_sel=1, y_sel=0. On ready: acc_ld=1, go to FETCH.
- EXEC, opcode 3 SUB: as ADD but alu_m=11.
- EXEC, opcode 4 JMP:
  - No memory access; alu_m=00, y_sel=1, pc_ld=1.
  - Goes to FETCH in 1 cycle.
- EXEC, opcode 5 JGE: as JMP but pc_ld = ~acc_neg. Goes to FETCH in 1 cycle regardless.
- EXEC, opcode 6 JNE: as JMP but pc_ld = ~acc_zero. Goes to FETCH in 1 cycle regardless.
- EXEC, opcode 7 STP: next state HALT.
- EXEC, opcodes 8-15: NOP, back to FETCH in 1 cycle (see optional feature).
- HALT: halted=1 and all other outputs 0. Only reset leaves HALT.
- Memory handshake rules:
  - mem_req and all request attributes stay stable until the mem_ready cycle.
  - The request deasserts in the cycle after completion.
  - mem_ready is ignored when mem_req=0.
  - Wait states are unbounded.
- Latency with zero wait states:
  - Memory instructions take 2 cycles.
  - Jumps and NOP take 2 cycles.
  - STP reaches HALT after 2 cycles.
- Flags are sampled combinationally during EXEC. If ACC changes in the same cycle, the pre-edge value is used.

Optional Feature:
- MU0_TRAP_EN defined:
  - Opcodes 8-15 in EXEC go to HALT instead of NOP.
  - An added output `trap` (1 bit) is set on entry to HALT and stays 1 until reset.
  - `trap` is 0 after a STP halt.
- Without MU0_TRAP_EN: opcodes 8-15 are single-cycle NOPs and the `trap` port does not exist.

Test Plan:
- Reset held 3 cycles, then released with mem_ready=1 and opcode=0: mem_req=0 throughout reset; first cycle after release shows mem_req=1, addr_sel=0, alu_m=10; ir_ld=pc_ld=1 that cycle.
- ADD (opcode 2) with mem_ready low for 3 EXEC cycles, then high: mem_req=1, addr_sel=1, alu_m=01, x_sel=1 stable for 4 cycles; acc_ld=1 only in the 4th cycle.
- STA (opcode 1), ready immediately: mem_we=1 for 1 cycle, acc_ld=0, then FETCH.
- JGE (opcode 5) with acc_neg=1 gives pc_ld=0; with acc_neg=0 gives pc_ld=1, alu_m=00, y_sel=1. JNE (opcode 6) with acc_zero=1 gives pc_ld=0. No mem_req in either.
- STP (opcode 7): halted=1 from cycle 3 onward; mem_ready toggling produces no outputs; reset returns to FETCH with halted=0.
- Opcode 9: with MU0_TRAP_EN, halted=trap=1; without it, back to FETCH next cycle and mem_req=1.
